bus_timer: RTL and testbench

//   Memory-mapped countdown timer; the device-side responder of the CPU peripheral bus.

---
 rtl/bus_timer_pkg.sv | 29 ++
 rtl/bus_timer.sv | 130 +++++++++++++
 tb/tb_bus_timer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg
//   Shared definitions for the memory-mapped countdown timer.
//   Covers the FSM state encoding, the register offsets decoded from
//   Addr[3:2], the CTRL bit positions and the MODE encodings.
package bus_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   // Word offsets, compared against Addr[3:2]
   localparam logic [1:0] CTRL_OFF   = 2'd0;
   localparam logic [1:0] PRESET_OFF = 2'd1;
   localparam logic [1:0] COUNT_OFF  = 2'd2;

   // CTRL bit indices
   localparam int EN_B    = 0;
   localparam int MODE_LO = 1;
   localparam int MODE_HI = 2;
   localparam int IM_B    = 3;

   // MODE encodings; 2'b1x is reserved and treated like one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/bus_timer.sv
// bus_timer
//   Memory-mapped countdown timer that responds on the CPU peripheral bus.
//   The address bridge decodes the 12-byte window, so this block only looks
//   at Addr[3:2]. It provides a CTRL/PRESET/COUNT register file, a
//   four-state countdown FSM and a maskable interrupt request. The timer
//   supports one-shot and auto-reload modes.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-high reset; clears all state
//   Addr   in   30  word address Addr[31:2]; only Addr[3:2] is decoded
//   we     in   1   full-word write enable
//   Din    in   32  write data
//   Dout   out  32  read data, combinational from Addr[3:2]
//   IRQ    out  1   interrupt request = irq_flag & CTRL.IM
//
// Configuration
//   BUS_TIMER_COUNT_WR_EN  when defined, a write to offset 0x8 loads COUNT.
//                          The write overrides that edge's FSM update of COUNT.
//                          When undefined, writes to 0x8 are ignored.
module bus_timer
   import bus_timer_pkg::*;
#(
   parameter int CNT_WIDTH = 32
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        we,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                 state;
   logic [3:0]             ctrl;
   logic [CNT_WIDTH-1:0]   preset;
   logic [CNT_WIDTH-1:0]   count;
   logic                   irq_flag;
   logic [1:0]             mode;
   logic                   wr_ctrl;
   logic                   wr_preset;
   logic                   wr_count;
   logic                   unused_addr;

   // The bridge has already matched the upper address bits to our window
   assign unused_addr = ^Addr[31:4];

   assign mode      = ctrl[MODE_HI:MODE_LO];
   assign wr_ctrl   = we && (Addr[3:2] == CTRL_OFF);
   assign wr_preset = we && (Addr[3:2] == PRESET_OFF);

`ifdef BUS_TIMER_COUNT_WR_EN
   assign wr_count = we && (Addr[3:2] == COUNT_OFF);
`else
   assign wr_count = 1'b0;
`endif

   assign IRQ = irq_flag & ctrl[IM_B];

   // Register file and countdown FSM share one process.
   // Bus writes are applied after the FSM update. As a result, a CTRL write
   // beats the hardware EN clear in INT, and it beats the irq_flag set.
   // A COUNT write, when enabled, likewise beats the FSM's COUNT update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl[EN_B])
                  state <= LOAD;
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!ctrl[EN_B]) begin
                  state <= IDLE;
               end else if (count > CNT_ONE) begin
                  count <= count - CNT_ONE;
               end else begin
                  // A COUNT of 0 or 1 expires here, so PRESET=0 acts like 1
                  count    <= '0;
                  irq_flag <= 1'b1;
                  state    <= INT;
               end
            end
            INT: begin
               // In reload mode, EN stays set, so IDLE immediately reloads
               if (mode == MODE_ONESHOT || mode[1])
                  ctrl[EN_B] <= 1'b0;
               else
                  irq_flag <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (wr_ctrl) begin
            ctrl     <= Din[3:0];
            irq_flag <= 1'b0;
         end
         if (wr_preset)
            preset <= Din[CNT_WIDTH-1:0];
         if (wr_count)
            count <= Din[CNT_WIDTH-1:0];
      end
   end

   // Read mux: registers are zero-extended and the unused slot reads zero
   always_comb begin
      Dout = '0;
      case (Addr[3:2])
         CTRL_OFF:   Dout[3:0]           = ctrl;
         PRESET_OFF: Dout[CNT_WIDTH-1:0] = preset;
         COUNT_OFF:  Dout[CNT_WIDTH-1:0] = count;
         default:    Dout                = '0;
      endcase
   end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer
//   Directed bench for bus_timer. Expected readbacks are queued with the
//   cycle number at which they are due; they are popped and compared
//   as the clock advances.
module tb_bus_timer;
   import bus_timer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] Addr;
   logic        we;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   localparam logic [1:0] RSVD_OFF = 2'd3;

   typedef struct {
      int          at;
      logic [1:0]  sel;
      logic [31:0] dout;
      logic        irq;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   t0;
   logic [31:0] exp_val;

   bus_timer #(.CNT_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .we    (we),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   // Reads one register and IRQ, then compares both against expectations
   task automatic checkOutput(input logic [1:0] sel, input logic [31:0] exp_dout,
                              input logic exp_irq, input string tag);
      Addr = {28'd0, sel};
      #1;
      checks++;
      assert (Dout === exp_dout) else begin
         failures++;
         $error("FAIL %s: Dout observed=%h expected=%h", tag, Dout, exp_dout);
      end
      checks++;
      assert (IRQ === exp_irq) else begin
         failures++;
         $error("FAIL %s: IRQ observed=%b expected=%b", tag, IRQ, exp_irq);
      end
   endtask

   // Queues an expectation, keeping the queue ordered by due cycle
   task automatic push(input int at, input logic [1:0] sel, input logic [31:0] dout,
                       input logic irq, input string tag);
      exp_t e;
      int   idx;
      e.at   = at;
      e.sel  = sel;
      e.dout = dout;
      e.irq  = irq;
      e.tag  = tag;
      idx = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].at > at) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, e);
   endtask

   // Advances one clock edge, then compares every expectation due now
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      we = 1'b0;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.at < cyc) begin
            checks++;
            failures++;
            $error("FAIL %s: expectation for cycle %0d missed, now %0d", e.tag, e.at, cyc);
         end else begin
            checkOutput(e.sel, e.dout, e.irq, e.tag);
         end
      end
   endtask

   // Performs a single bus write, which lands at the next clock edge
   task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] data);
      Addr = {28'd0, sel};
      Din  = data;
      we   = 1'b1;
      tick();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // Runs until every queued expectation has been compared, within a budget
   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      Addr  = '0;
      Din   = '0;
      #12;
      checkOutput(CTRL_OFF,   32'd0, 1'b0, "por_ctrl");
      checkOutput(PRESET_OFF, 32'd0, 1'b0, "por_preset");
      checkOutput(COUNT_OFF,  32'd0, 1'b0, "por_count");
      reset = 1'b0;
      tick();

      // Reset asserted partway through a PRESET=10 run
      applyStimulus(PRESET_OFF, 32'd10);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      push(t0 + 5, COUNT_OFF, 32'd7, 1'b0, "rst_running");
      run_to(t0 + 6);
      #1;
      reset = 1'b1;
      checkOutput(CTRL_OFF,   32'd0, 1'b0, "rst_ctrl");
      checkOutput(PRESET_OFF, 32'd0, 1'b0, "rst_preset");
      checkOutput(COUNT_OFF,  32'd0, 1'b0, "rst_count");
      checkOutput(RSVD_OFF,   32'd0, 1'b0, "rst_rsvd");
      reset = 1'b0;
      push(t0 + 12, COUNT_OFF, 32'd0, 1'b0, "rst_no_irq_a");
      push(t0 + 14, CTRL_OFF,  32'd0, 1'b0, "rst_no_irq_b");
      drain(40);

      // One-shot mode: with PRESET=5, IRQ rises after edge t0+7
      applyStimulus(PRESET_OFF, 32'd5);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      push(t0 + 2,  COUNT_OFF, 32'd5, 1'b0, "os_load");
      push(t0 + 3,  COUNT_OFF, 32'd4, 1'b0, "os_dec");
      push(t0 + 6,  COUNT_OFF, 32'd1, 1'b0, "os_pre_irq");
      push(t0 + 7,  CTRL_OFF,  32'h9, 1'b1, "os_irq");
      push(t0 + 8,  CTRL_OFF,  32'h8, 1'b1, "os_en_clr");
      push(t0 + 12, COUNT_OFF, 32'd0, 1'b1, "os_hold");
      drain(40);
      applyStimulus(CTRL_OFF, 32'h8);
      checkOutput(CTRL_OFF, 32'h8, 1'b0, "os_ack");

      // Reload mode: a one-cycle pulse with five quiet cycles in between
      applyStimulus(PRESET_OFF, 32'd3);
      applyStimulus(CTRL_OFF, 32'hB);
      t0 = cyc;
      push(t0 + 4,  COUNT_OFF, 32'd1, 1'b0, "rl_pre");
      push(t0 + 5,  COUNT_OFF, 32'd0, 1'b1, "rl_pulse1");
      push(t0 + 6,  CTRL_OFF,  32'hB, 1'b0, "rl_drop1");
      push(t0 + 8,  COUNT_OFF, 32'd3, 1'b0, "rl_cnt3");
      push(t0 + 9,  COUNT_OFF, 32'd2, 1'b0, "rl_cnt2");
      push(t0 + 10, COUNT_OFF, 32'd1, 1'b0, "rl_cnt1");
      push(t0 + 11, COUNT_OFF, 32'd0, 1'b1, "rl_pulse2");
      push(t0 + 12, COUNT_OFF, 32'd0, 1'b0, "rl_drop2");
      push(t0 + 17, COUNT_OFF, 32'd0, 1'b1, "rl_pulse3");
      drain(40);
      applyStimulus(CTRL_OFF, 32'h0);
      checkOutput(CTRL_OFF, 32'h0, 1'b0, "rl_stop");

      // Clearing EN partway through freezes COUNT
      applyStimulus(PRESET_OFF, 32'd8);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      push(t0 + 3, COUNT_OFF, 32'd7, 1'b0, "stop_run");
      drain(20);
      applyStimulus(CTRL_OFF, 32'h8);
      checkOutput(COUNT_OFF, 32'd6, 1'b0, "stop_at_write");
      push(t0 + 5,  COUNT_OFF, 32'd6, 1'b0, "stop_frozen_a");
      push(t0 + 12, COUNT_OFF, 32'd6, 1'b0, "stop_frozen_b");
      push(t0 + 20, CTRL_OFF,  32'h8, 1'b0, "stop_ctrl");
      drain(40);

      // With IM=0, the run completes but IRQ stays masked
      applyStimulus(CTRL_OFF, 32'h1);
      t0 = cyc;
      push(t0 + 2,  COUNT_OFF, 32'd8, 1'b0, "mask_load");
      push(t0 + 9,  COUNT_OFF, 32'd1, 1'b0, "mask_pre");
      push(t0 + 10, COUNT_OFF, 32'd0, 1'b0, "mask_expire");
      push(t0 + 11, CTRL_OFF,  32'h0, 1'b0, "mask_en_clr");
      push(t0 + 15, COUNT_OFF, 32'd0, 1'b0, "mask_hold");
      drain(40);
      applyStimulus(CTRL_OFF, 32'h8);
      checkOutput(CTRL_OFF, 32'h8, 1'b0, "flag_cleared_by_ctrl_wr");

      // Writes to the reserved slot and to read-only bits are ignored
      applyStimulus(RSVD_OFF, 32'hFFFF_FFFF);
      checkOutput(RSVD_OFF,   32'd0, 1'b0, "rsvd_read");
      checkOutput(CTRL_OFF,   32'h8, 1'b0, "rsvd_ctrl_keep");
      checkOutput(PRESET_OFF, 32'd8, 1'b0, "rsvd_preset_keep");
      applyStimulus(COUNT_OFF, 32'h55);
`ifdef BUS_TIMER_COUNT_WR_EN
      exp_val = 32'h55;
`else
      exp_val = 32'h0;
`endif
      checkOutput(COUNT_OFF, exp_val, 1'b0, "count_wr_idle");
      applyStimulus(CTRL_OFF, 32'hFFFF_FFF0);
      checkOutput(CTRL_OFF, 32'h0, 1'b0, "ctrl_upper_ignored");

      // A PRESET write during CNT does not change the current run
      applyStimulus(PRESET_OFF, 32'd6);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      run_to(t0 + 3);
      applyStimulus(PRESET_OFF, 32'd20);
      push(t0 + 5, PRESET_OFF, 32'd20, 1'b0, "pw_preset_new");
      push(t0 + 7, COUNT_OFF,  32'd1,  1'b0, "pw_pre");
      push(t0 + 8, COUNT_OFF,  32'd0,  1'b1, "pw_irq");
      drain(40);
      applyStimulus(CTRL_OFF, 32'h0);

      // A bus CTRL write in INT beats the one-shot EN clear
      applyStimulus(PRESET_OFF, 32'd2);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      push(t0 + 3, COUNT_OFF, 32'd1, 1'b0, "coll_pre");
      push(t0 + 4, CTRL_OFF,  32'h9, 1'b1, "coll_irq");
      drain(20);
      applyStimulus(CTRL_OFF, 32'h9);
      checkOutput(CTRL_OFF, 32'h9, 1'b0, "coll_bus_wins");
      push(t0 + 8, COUNT_OFF, 32'd1, 1'b0, "coll_rerun_pre");
      push(t0 + 9, COUNT_OFF, 32'd0, 1'b1, "coll_rerun_irq");
      drain(20);
      applyStimulus(CTRL_OFF, 32'h0);

      // PRESET=0 behaves like PRESET=1
      applyStimulus(PRESET_OFF, 32'd0);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      push(t0 + 2, COUNT_OFF, 32'd0, 1'b0, "p0_pre");
      push(t0 + 3, COUNT_OFF, 32'd0, 1'b1, "p0_irq");
      drain(20);
      applyStimulus(CTRL_OFF, 32'h0);

      // A COUNT write in the middle of a long run
      applyStimulus(PRESET_OFF, 32'd100);
      applyStimulus(CTRL_OFF, 32'h9);
      t0 = cyc;
      run_to(t0 + 9);
      applyStimulus(COUNT_OFF, 32'd2);
`ifdef BUS_TIMER_COUNT_WR_EN
      checkOutput(COUNT_OFF, 32'd2, 1'b0, "cw_loaded");
      push(t0 + 11, COUNT_OFF, 32'd1, 1'b0, "cw_pre");
      push(t0 + 12, COUNT_OFF, 32'd0, 1'b1, "cw_irq");
`else
      checkOutput(COUNT_OFF, 32'd92, 1'b0, "cw_ignored");
      push(t0 + 12, COUNT_OFF, 32'd90, 1'b0, "cw_no_irq");
`endif
      drain(20);
      applyStimulus(CTRL_OFF, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
